// File: rtl/alu_pkg.sv
// Shared definitions for the ALU divide path.
// Holds the divider state encoding, the default operand width and the
// quotient value a divide-by-zero produces.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = 5;

    // Divider FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Quotient left by the unmodified algorithm when the divisor is zero
    localparam logic [DEF_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/alu_divider_div_step.sv
// div_step: one restoring-division iteration, purely combinational.
// Ports:
//   i_rem     partial remainder before the iteration
//   i_msb     dividend bit shifted into the remainder
//   i_dvs     divisor
//   o_rem_c   partial remainder after the iteration
//   o_qbit_c  quotient bit produced by the iteration
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem_c,
    output logic             o_qbit_c
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_diff_msb;

    // Shifted remainder keeps its top bit so the compare spans WIDTH+1 bits
    assign w_trial = {i_rem, i_msb};

    // Borrow out of the WIDTH+1-bit subtract decides the quotient bit
    assign w_diff   = {1'b0, w_trial} - {2'b00, i_dvs};
    assign o_qbit_c = ~w_diff[WIDTH+1];

    // On a successful subtract the result is below the divisor, so bit WIDTH is zero
    assign w_unused_diff_msb = w_diff[WIDTH];

    assign o_rem_c = o_qbit_c ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule

// File: rtl/alu_divider.sv
// alu_divider: sequential unsigned restoring divider, one quotient bit per
// enabled cycle. Results hold on divq/divr until the next division completes.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   numer, denom    dividend and divisor, sampled only in LOAD
//   dclken          iteration enable (stalls RUN while low)
//   daclr           synchronous start / abort, loads the operands
//   divq, divr      quotient / remainder of the last completed division
//   busy            division in progress
//   done            one-cycle pulse when divq/divr update
//   dbz             last completed division had a zero divisor
// Build option: ALU_DIVIDER_AUTOSTART_EN also starts a division from IDLE
// when dclken is high and the operands differ from those last loaded.
module alu_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    input  logic             dclken,
    input  logic             daclr,
    output logic [WIDTH-1:0] divq,
    output logic [WIDTH-1:0] divr,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz_pend;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic             w_iter;
    logic             w_auto;

`ifdef ALU_DIVIDER_AUTOSTART_EN
    logic [2*WIDTH-1:0] r_shadow;

    // Operand change seen while enabled restarts the division on its own
    assign w_auto = dclken && ({numer, denom} != r_shadow);

    // Operands of the most recent LOAD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (r_state == ST_LOAD) begin
            r_shadow <= {numer, denom};
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    // An abort takes priority over an iteration in the same cycle
    assign w_iter = (r_state == ST_RUN) && dclken && !daclr;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_rem   (r_rem),
        .i_msb   (r_dvd[WIDTH-1]),
        .i_dvs   (r_dvs),
        .o_rem_c (w_rem_next),
        .o_qbit_c(w_qbit)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; daclr outside IDLE aborts back into LOAD
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (daclr || w_auto) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = daclr ? ST_LOAD : ST_RUN;
            end
            ST_RUN: begin
                if (daclr) begin
                    w_next = ST_LOAD;
                end else if (dclken && (r_cnt == CNT_W'(1))) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = daclr ? ST_LOAD : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Working registers: load operands, then shift/subtract once per enabled cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_dbz_pend <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_dvd      <= numer;
            r_dvs      <= denom;
            r_rem      <= '0;
            r_cnt      <= CNT_W'(WIDTH);
            r_dbz_pend <= (denom == '0);
        end else if (w_iter) begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Registered outputs; results publish only when DONE completes without abort
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divq <= '0;
            divr <= '0;
            dbz  <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            busy <= (w_next == ST_LOAD) || (w_next == ST_RUN);
            done <= 1'b0;
            if ((r_state == ST_DONE) && !daclr) begin
                divq <= r_dvd;
                divr <= r_rem;
                dbz  <= r_dbz_pend;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: the driver pushes the expected result and
// completion cycle of each division; a monitor pops and compares on done.
module tb_alu_divider;

    localparam int unsigned W = 16;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] numer;
    logic [W-1:0] denom;
    logic         dclken;
    logic         daclr;
    logic [W-1:0] divq;
    logic [W-1:0] divr;
    logic         busy;
    logic         done;
    logic         dbz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    alu_divider #(
        .WIDTH(W),
        .CNT_W(5)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .numer  (numer),
        .denom  (denom),
        .dclken (dclken),
        .daclr  (daclr),
        .divq   (divq),
        .divr   (divr),
        .busy   (busy),
        .done   (done),
        .dbz    (dbz)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all ones and the dividend back
    function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d, input int c);
        exp_t e;
        e.z   = (d == '0);
        e.q   = e.z ? '1 : n / d;
        e.r   = e.z ? n : n % d;
        e.cyc = c;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done divq=%0h divr=%0h at cycle %0d", divq, divr, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("divq", 32'(divq), 32'(mon_e.q));
                chk("divr", 32'(divr), 32'(mon_e.r));
                chk("dbz", 32'(dbz), 32'(mon_e.z));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Pulse daclr with new operands; c0 is the edge that sampled it
    task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d);
        numer = n;
        denom = d;
        daclr = 1'b1;
        @(negedge clock);
        daclr = 1'b0;
        c0    = cyc;
        chk("busy_load", 32'(busy), 32'd1);
    endtask

    // Drive k enabled iterations (mode 0 always on, 1 toggling, 2 random); operands scrambled during RUN
    task automatic iterate(input logic [W-1:0] n, input logic [W-1:0] d, input int k,
                           input int mode, output int lows);
        int got = 0;
        int t   = 0;
        lows   = 0;
        dclken = (mode == 0);
        @(negedge clock);
        while (got < k) begin
            numer = W'($urandom);
            denom = W'($urandom);
            case (mode)
                0:       dclken = 1'b1;
                1:       begin dclken = t[0]; t++; end
                default: dclken = 1'($urandom_range(0, 1));
            endcase
            @(negedge clock);
            if (dclken) got++;
            else lows++;
        end
        numer  = n;
        denom  = d;
        dclken = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic expect_op(input logic [W-1:0] n, input logic [W-1:0] d, input int lows);
        exp_t e;
        e = model(n, d, c0 + int'(W) + 2 + lows);
        sb.push_back(e);
        last_q = e.q;
        last_r = e.r;
    endtask

    task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d, input int mode);
        int lows;
        start_op(n, d);
        iterate(n, d, int'(W), mode, lows);
        expect_op(n, d, lows);
        drain();
    endtask

    initial begin
        int           lows;
        logic [W-1:0] rn;
        logic [W-1:0] rd;
        reset_n = 1'b0;
        numer   = '0;
        denom   = '0;
        dclken  = 1'b0;
        daclr   = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_divq", 32'(divq), 32'd0);
        chk("rst_divr", 32'(divr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_div(16'd100, 16'd7, 0);
        run_div(16'hFFFF, 16'h0010, 1);
        run_div(16'h1234, 16'h0000, 0);
        run_div(16'd9, 16'd3, 2);

        // Abort mid-run: old results must hold and only the second op completes
        start_op(16'd50000, 16'd3);
        iterate(16'd50000, 16'd3, 8, 0, lows);
        chk("abort_hold_q", 32'(divq), 32'(last_q));
        chk("abort_hold_r", 32'(divr), 32'(last_r));
        start_op(16'd81, 16'd9);
        iterate(16'd81, 16'd9, int'(W), 0, lows);
        chk("abort_pre_done_q", 32'(divq), 32'(last_q));
        expect_op(16'd81, 16'd9, lows);
        drain();

        // Asynchronous reset during RUN
        start_op(16'h1234, 16'h0056);
        iterate(16'h1234, 16'h0056, 5, 0, lows);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_divq", 32'(divq), 32'd0);
        chk("midrst_divr", 32'(divr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dbz", 32'(dbz), 32'd0);
        numer = '0;
        denom = '0;
        @(negedge clock);
        reset_n = 1'b1;
        last_q  = '0;
        last_r  = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (i % 8 == 7) chk("post_rst_busy", 32'(busy), 32'd0);
        end

        run_div(16'd0, 16'd5, 0);
        run_div(16'd5, 16'hFFFF, 0);
        run_div(16'hFFFF, 16'd1, 1);

        for (int i = 0; i < 20; i++) begin
            rn = W'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            run_div(rn, rd, int'($urandom_range(0, 2)));
        end

`ifdef ALU_DIVIDER_AUTOSTART_EN
        run_div(16'd20, 16'd4, 0);
        numer  = 16'd21;
        dclken = 1'b1;
        @(negedge clock);
        c0 = cyc;
        chk("auto_busy", 32'(busy), 32'd1);
        iterate(16'd21, 16'd4, int'(W), 0, lows);
        expect_op(16'd21, 16'd4, lows);
        drain();
`endif

        repeat (4) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
